// File: rtl/wt_mem_rsp_pkg.sv
// Shared types and helpers for the write-through memory responder.
package wt_mem_rsp_pkg;

  localparam int unsigned ADDR_MAX_W = 64;
  localparam int unsigned TID_MAX_W  = 8;

  typedef enum logic [1:0] {
    LOAD  = 2'd0,
    STORE = 2'd1,
    IFILL = 2'd2
  } req_type_t;

  typedef struct packed {
    req_type_t               rtype;
    logic [ADDR_MAX_W-1:0]   addr;
    logic [63:0]             wdata;
    logic [7:0]              be;
    logic [TID_MAX_W-1:0]    tid;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } fsm_state_t;

  function automatic int unsigned line_off_w(int unsigned line_w);
    return $clog2(line_w / 8);
  endfunction

  function automatic int unsigned line_idx_w(int unsigned mem_lines);
    return (mem_lines > 1) ? $clog2(mem_lines) : 1;
  endfunction

  function automatic logic [63:0] bswap64(logic [63:0] w);
    logic [63:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i*8 +: 8] = w[(7-i)*8 +: 8];
    return r;
  endfunction

  function automatic logic [7:0] brev8(logic [7:0] b);
    logic [7:0] r;
    r = '0;
    for (int unsigned i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

endpackage

// File: rtl/wt_mem_req_fifo.sv
// In-order request buffer of req_t; push is ignored when full, pop when empty.
module wt_mem_req_fifo
  import wt_mem_rsp_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  req_t                     data_i,
  input  logic                     pop_i,
  output req_t                     data_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   usage_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);

  req_t             mem_q [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [PTR_W:0]   cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign full_o  = (cnt_q == (PTR_W+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign usage_o = cnt_q;
  assign data_o  = mem_q[rptr_q];

  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    if (do_push) wptr_d = wptr_q + 1'b1;
    if (do_pop)  rptr_d = rptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/wt_mem_responder.sv
// Memory-side responder for the write-through cache miss port: buffered, fixed-latency, in-order.
// Define WT_MEM_RSP_BIG_ENDIAN_EN to byte-reverse each 64-bit word of data/byte enables at the ports.
module wt_mem_responder
  import wt_mem_rsp_pkg::*;
#(
  parameter int unsigned LINE_W     = 128,
  parameter int unsigned ADDR_W     = 64,
  parameter int unsigned TID_W      = 2,
  parameter int unsigned MEM_LINES  = 256,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned LATENCY    = 3
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  req_type_t         req_type_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [63:0]       req_wdata_i,
  input  logic [7:0]        req_be_i,
  input  logic [TID_W-1:0]  req_tid_i,
  output logic              rsp_valid_o,
  input  logic              rsp_ready_i,
  output req_type_t         rsp_type_o,
  output logic [TID_W-1:0]  rsp_tid_o,
  output logic [LINE_W-1:0] rsp_data_o,
  output logic              busy_o
);

  localparam int unsigned OFF_W  = line_off_w(LINE_W);
  localparam int unsigned IDX_W  = line_idx_w(MEM_LINES);
  localparam int unsigned WORDS  = LINE_W / 64;
  localparam int unsigned LANE_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam int unsigned CNT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

  req_t                      req_in, head;
  logic                      fifo_full, fifo_empty, fifo_pop;
  logic [$clog2(FIFO_DEPTH):0] fifo_usage;
  logic [63:0]               wdata_in;
  logic [7:0]                be_in;

  fsm_state_t                state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  req_type_t                 cur_type_q, cur_type_d;
  logic [TID_W-1:0]          cur_tid_q, cur_tid_d;
  logic [IDX_W-1:0]          cur_idx_q, cur_idx_d;
  req_type_t                 rsp_type_q, rsp_type_d;
  logic [TID_W-1:0]          rsp_tid_q, rsp_tid_d;
  logic [LINE_W-1:0]         rsp_data_q, rsp_data_d;

  logic [LINE_W-1:0]         mem_q [MEM_LINES];
  logic [LINE_W-1:0]         rd_line, rd_line_pres;
  logic [IDX_W-1:0]          head_idx;
  logic [LANE_W-1:0]         head_lane;
  logic                      store_we;
  logic                      unused_head;

`ifdef WT_MEM_RSP_BIG_ENDIAN_EN
  assign wdata_in = bswap64(req_wdata_i);
  assign be_in    = brev8(req_be_i);
  always_comb begin
    rd_line_pres = '0;
    for (int unsigned w = 0; w < WORDS; w++) rd_line_pres[w*64 +: 64] = bswap64(rd_line[w*64 +: 64]);
  end
`else
  assign wdata_in     = req_wdata_i;
  assign be_in        = req_be_i;
  assign rd_line_pres = rd_line;
`endif

  always_comb begin
    req_in       = '0;
    req_in.rtype = req_type_i;
    req_in.addr  = ADDR_MAX_W'(req_addr_i);
    req_in.wdata = wdata_in;
    req_in.be    = be_in;
    req_in.tid   = TID_MAX_W'(req_tid_i);
  end

  wt_mem_req_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (req_valid_i),
    .data_i  (req_in),
    .pop_i   (fifo_pop),
    .data_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .usage_o (fifo_usage)
  );

  assign req_ready_o = !fifo_full;
  assign rsp_valid_o = (state_q == RESP);
  assign rsp_type_o  = rsp_type_q;
  assign rsp_tid_o   = rsp_tid_q;
  assign rsp_data_o  = rsp_data_q;
  assign busy_o      = (fifo_usage != '0) || (state_q != IDLE);

  // Upper address bits alias; only the line index and word lane are decoded.
  assign head_idx    = IDX_W'(head.addr >> OFF_W);
  assign head_lane   = LANE_W'((head.addr >> 3) & ADDR_MAX_W'(WORDS - 1));
  assign store_we    = fifo_pop && (head.rtype == STORE);
  assign rd_line     = mem_q[cur_idx_q];
  assign unused_head = ^head;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cur_type_d = cur_type_q;
    cur_tid_d  = cur_tid_q;
    cur_idx_d  = cur_idx_q;
    rsp_type_d = rsp_type_q;
    rsp_tid_d  = rsp_tid_q;
    rsp_data_d = rsp_data_q;
    fifo_pop   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          fifo_pop = 1'b1;
          state_d  = ACCESS;
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          rsp_type_d = cur_type_q;
          rsp_tid_d  = cur_tid_q;
          rsp_data_d = (cur_type_q == STORE) ? '0 : rd_line_pres;
          state_d    = RESP;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      RESP: begin
        if (rsp_ready_i) begin
          if (!fifo_empty) begin
            fifo_pop = 1'b1;
            state_d  = ACCESS;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // A pop from IDLE or straight out of RESP loads the same service context.
    if (fifo_pop) begin
      cnt_d      = CNT_W'(LATENCY - 1);
      cur_type_d = head.rtype;
      cur_tid_d  = TID_W'(head.tid);
      cur_idx_d  = head_idx;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      cur_type_q <= LOAD;
      cur_tid_q  <= '0;
      cur_idx_q  <= '0;
      rsp_type_q <= LOAD;
      rsp_tid_q  <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cur_type_q <= cur_type_d;
      cur_tid_q  <= cur_tid_d;
      cur_idx_q  <= cur_idx_d;
      rsp_type_q <= rsp_type_d;
      rsp_tid_q  <= rsp_tid_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (store_we) begin
      for (int unsigned b = 0; b < 8; b++) begin
        if (head.be[b]) mem_q[head_idx][{head_lane, 3'(b), 3'b000} +: 8] <= head.wdata[b*8 +: 8];
      end
    end
  end

endmodule

// File: tb/tb_wt_mem_responder.sv
// Directed bench for wt_mem_responder with a line-model scoreboard checked on every response.
module tb_wt_mem_responder;
  import wt_mem_rsp_pkg::*;

  localparam int unsigned LAT = 3;

  logic         clk, rst_n;
  logic         req_valid, req_ready;
  req_type_t    req_type;
  logic [63:0]  req_addr, req_wdata;
  logic [7:0]   req_be;
  logic [1:0]   req_tid;
  logic         rsp_valid, rsp_ready;
  req_type_t    rsp_type;
  logic [1:0]   rsp_tid;
  logic [127:0] rsp_data;
  logic         busy;

  typedef struct {
    req_type_t    t;
    logic [1:0]   tid;
    logic [127:0] data;
    logic [127:0] mask;
  } exp_t;

  exp_t         sbq[$];
  exp_t         e;
  logic [127:0] mdl   [256];
  logic [127:0] known [256];
  int           checks = 0;
  int           errors = 0;

  wt_mem_responder #(
    .LINE_W     (128),
    .ADDR_W     (64),
    .TID_W      (2),
    .MEM_LINES  (256),
    .FIFO_DEPTH (4),
    .LATENCY    (LAT)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .req_type_i  (req_type),
    .req_addr_i  (req_addr),
    .req_wdata_i (req_wdata),
    .req_be_i    (req_be),
    .req_tid_i   (req_tid),
    .rsp_valid_o (rsp_valid),
    .rsp_ready_i (rsp_ready),
    .rsp_type_o  (rsp_type),
    .rsp_tid_o   (rsp_tid),
    .rsp_data_o  (rsp_data),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n && rsp_valid && rsp_ready) begin
      if (sbq.size() == 0) begin
        chk("rsp_outstanding", 128'(sbq.size()), 128'd1);
      end else begin
        e = sbq.pop_front();
        chk("rsp_type", 128'(rsp_type), 128'(e.t));
        chk("rsp_tid",  128'(rsp_tid),  128'(e.tid));
        chk("rsp_data", rsp_data & e.mask, e.data & e.mask);
      end
    end
  end

  task automatic push(input req_type_t t, input logic [63:0] a, input logic [63:0] wd,
                      input logic [7:0] be, input logic [1:0] tid);
    int          n;
    int unsigned idx, lane;
    n = 0;
    idx  = int'(a[11:4]);
    lane = int'(a[3]);
    @(posedge clk); #1;
    req_valid = 1'b1; req_type = t; req_addr = a; req_wdata = wd; req_be = be; req_tid = tid;
    @(negedge clk);
    while (!req_ready && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!req_ready) begin
      chk("push_timeout", 128'(req_ready), 128'd1);
      req_valid = 1'b0;
    end else begin
      @(posedge clk); #1;
      req_valid = 1'b0;
      if (t == STORE) begin
        for (int unsigned b = 0; b < 8; b++) begin
          if (be[b]) begin
            mdl[idx][lane*64 + b*8 +: 8]   = wd[b*8 +: 8];
            known[idx][lane*64 + b*8 +: 8] = 8'hFF;
          end
        end
        sbq.push_back('{t: STORE, tid: tid, data: '0, mask: '1});
      end else begin
        sbq.push_back('{t: t, tid: tid, data: mdl[idx], mask: known[idx]});
      end
    end
  endtask

  // Request just accepted into an idle responder: pop on the next edge, valid LAT edges later.
  task automatic check_latency(input string tag);
    repeat (LAT + 1) begin
      @(negedge clk);
      chk({tag, "_early"}, 128'(rsp_valid), 128'd0);
    end
    @(negedge clk);
    chk(tag, 128'(rsp_valid), 128'd1);
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    @(negedge clk);
    while ((busy || sbq.size() != 0) && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk("drain", 128'({busy, sbq.size() != 0}), 128'd0);
  endtask

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_type = LOAD; req_addr = '0;
    req_wdata = '0; req_be = '0; req_tid = '0; rsp_ready = 1'b1;
    for (int i = 0; i < 256; i++) begin
      mdl[i] = '0;
      known[i] = '0;
    end

    repeat (3) @(negedge clk);
    chk("rst_ready", 128'(req_ready), 128'd1);
    chk("rst_valid", 128'(rsp_valid), 128'd0);
    chk("rst_type",  128'(rsp_type),  128'd0);
    chk("rst_tid",   128'(rsp_tid),   128'd0);
    chk("rst_data",  rsp_data,        128'd0);
    chk("rst_busy",  128'(busy),      128'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("idle_ready", 128'(req_ready), 128'd1);
      chk("idle_valid", 128'(rsp_valid), 128'd0);
      chk("idle_busy",  128'(busy),      128'd0);
    end

    push(STORE, 64'h40, 64'h1122334455667788, 8'hFF, 2'd1);
    check_latency("store_lat");
    wait_idle();
    push(LOAD, 64'h40, '0, '0, 2'd2);
    check_latency("load_lat");
    wait_idle();

    push(STORE, 64'h48, 64'h0, 8'hFF, 2'd0);
    push(STORE, 64'h48, 64'hAAAAAAAA_BBBBBBBB, 8'h0F, 2'd1);
    push(IFILL, 64'h40, '0, '0, 2'd2);
    wait_idle();

    push(STORE, 64'h40, 64'hDEADBEEF_DEADBEEF, 8'h00, 2'd3);
    push(LOAD,  64'h40, '0, '0, 2'd0);
    wait_idle();

    rsp_ready = 1'b0;
    push(LOAD,  64'h40, '0, '0, 2'd0);
    push(IFILL, 64'h48, '0, '0, 2'd1);
    push(LOAD,  64'h80, '0, '0, 2'd2);
    push(LOAD,  64'h48, '0, '0, 2'd3);
    push(IFILL, 64'h40, '0, '0, 2'd0);
    @(negedge clk);
    chk("full_ready", 128'(req_ready), 128'd0);
    chk("full_busy",  128'(busy),      128'd1);
    @(posedge clk); #1;
    req_valid = 1'b1; req_type = LOAD; req_addr = 64'h40; req_tid = 2'd1;
    repeat (3) begin
      @(negedge clk);
      chk("held_ready", 128'(req_ready), 128'd0);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    push(LOAD, 64'h40, '0, '0, 2'd1);
    wait_idle();

    rsp_ready = 1'b0;
    push(LOAD, 64'h40, '0, '0, 2'd3);
    push(LOAD, 64'h48, '0, '0, 2'd1);
    n = 0;
    while (!rsp_valid && n < 50) begin
      n++;
      @(negedge clk);
    end
    repeat (10) begin
      @(negedge clk);
      chk("bp_valid", 128'(rsp_valid),     128'd1);
      chk("bp_type",  128'(rsp_type),      128'(LOAD));
      chk("bp_tid",   128'(rsp_tid),       128'd3);
      chk("bp_data",  128'(rsp_data[63:0]), 128'h1122334455667788);
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    repeat (LAT) begin
      @(negedge clk);
      chk("nobubble_early", 128'(rsp_valid), 128'd0);
    end
    @(negedge clk);
    chk("nobubble", 128'(rsp_valid), 128'd1);
    wait_idle();

    push(STORE, 64'h80, 64'hCAFEF00D_12345678, 8'hFF, 2'd2);
    wait_idle();
    rsp_ready = 1'b0;
    push(LOAD, 64'h40, '0, '0, 2'd0);
    push(LOAD, 64'h40, '0, '0, 2'd1);
    push(LOAD, 64'h48, '0, '0, 2'd2);
    push(LOAD, 64'h80, '0, '0, 2'd3);
    @(negedge clk);
    chk("mid_valid", 128'(rsp_valid), 128'd1);
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    sbq.delete();
    #1;
    chk("mid_rst_valid", 128'(rsp_valid), 128'd0);
    chk("mid_rst_busy",  128'(busy),      128'd0);
    chk("mid_rst_ready", 128'(req_ready), 128'd1);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) begin
      @(negedge clk);
      chk("post_rst_valid", 128'(rsp_valid), 128'd0);
      chk("post_rst_busy",  128'(busy),      128'd0);
    end
    push(LOAD, 64'h80, '0, '0, 2'd1);
    wait_idle();

    push(STORE, 64'hC0, 64'h0102030405060708, 8'hFF, 2'd0);
    wait_idle();
`ifdef WT_MEM_RSP_BIG_ENDIAN_EN
    chk("be_internal", 128'(dut.mem_q[12][63:0]), 128'h0807060504030201);
`endif
    push(LOAD, 64'hC0, '0, '0, 2'd1);
    wait_idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
